y_signature_misr: RTL and testbench
===================================

// Module: y_signature_misr
// PURPOSE
//  Downstream consumer of the DUT result bus y. Replaces per-cycle $strobe dumps.
//  Compacts y into a SIG_WIDTH multiple-input signature register (MISR) over a window
//  of NUM_SAMPLES consecutive clocks. Then presents the signature on a valid/ready handshake.
//  Two netlists (synth vs. reference) are compared by signature alone.
// PARAMETERS
//  Y_WIDTH      446            width of the sampled DUT output bus y
//  SIG_WIDTH    32             MISR / signature width (>=2)
//  POLY         32'h04C11DB7   feedback polynomial (bit i = tap i); width SIG_WIDTH
//  SEED         32'h0          value loaded into the MISR when a capture starts
//  NUM_SAMPLES  20             samples absorbed per capture window (>=1)
// PORTS
//  clk          in   1                      single clock; all state updates on posedge
//  rst          in   1                      synchronous, active-high reset
//  y            in   Y_WIDTH                DUT output bus sampled each CAPTURE cycle
//  start        in   1                      request a capture window; honoured only in IDLE
//  busy         out  1                      1 in CAPTURE or HOLD
//  sig_valid    out  1                      signature available (HOLD state)
//  sig_ready    in   1                      consumer accepts signature
//  signature    out  SIG_WIDTH              MISR contents
//  sample_count out  $clog2(NUM_SAMPLES+1)  samples absorbed in current/last window
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; busy=0, sig_valid=0, signature=0, sample_count=0.
//   Reset has priority over every other input, including mid-CAPTURE and mid-HOLD.
//   A partial signature is discarded.
//  Fold: y is zero-extended to ceil(Y_WIDTH/SIG_WIDTH)*SIG_WIDTH bits.
//   It is split into SIG_WIDTH chunks: chunk k = bits [k*SIG_WIDTH +: SIG_WIDTH].
//   fold(y) = XOR of all chunks. For the defaults: 14 chunks, top chunk uses bits 445:416.
//  MISR step: sig' = {sig[SIG_WIDTH-2:0],1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : 0) ^ fold(y).
//  FSM:
//   IDLE    start=1 -> CAPTURE. signature<=SEED, sample_count<=0. Otherwise hold all outputs.
//   CAPTURE every cycle: signature<=step(signature,y), sample_count+=1.
//            On the cycle sample_count==NUM_SAMPLES-1, absorb that final sample and go to HOLD.
//            start is ignored.
//   HOLD    sig_valid=1. signature and sample_count are frozen.
//            sig_ready=1 -> IDLE (handshake completes on that edge).
//            sig_ready=0 -> stay; the signature must not change.
//            start is ignored, even if it is simultaneous with sig_ready.
//  Latency: if start is sampled at edge k, y is absorbed at edges k+1 .. k+NUM_SAMPLES.
//   sig_valid=1 from edge k+NUM_SAMPLES onward. IDLE is re-entered no earlier than edge k+NUM_SAMPLES+1.
//  After the handshake, signature and sample_count keep the last values (readable in IDLE)
//   until the next start is accepted.
//  sample_count never exceeds NUM_SAMPLES and never wraps.
//  Back-to-back windows: start may be high on the same edge the FSM returns to IDLE.
//   It is only accepted on a later edge, when the FSM is in IDLE.
//  All outputs are registered; there is no combinational path from any input to any output.
//  Width rules: fold, step and POLY are all exactly SIG_WIDTH bits; shift-out bits are dropped.
// TESTING
//  T1 SEED=0, N=20, y=0 every cycle, pulse start -> sig_valid at edge start+20,
//     signature=32'h0, sample_count=20.
//  T2 SEED=32'h80000000, N=1, y=0 -> signature=32'h04C11DB7.
//     SEED=32'h1, N=1, y=0 -> signature=32'h2.
//  T3 Fold check, SEED=0, N=1: y=1<<0 -> 32'h1; y=1<<32 -> 32'h1;
//     y=(1<<32)|1 -> 32'h0; y=1<<445 -> 32'h20000000.
//  T4 Handshake: hold sig_ready=0 for 5 cycles in HOLD while toggling y and start.
//     sig_valid stays 1, signature stable. sig_ready=1 -> IDLE next edge, busy=0.
//  T5 Reset mid-CAPTURE (after 7 of 20 samples): next edge all outputs 0, IDLE.
//     A new start with the same stimulus gives the same signature as an uninterrupted run.
//  T6 Replay the 20 DUT stimulus vectors twice with the same SEED.
//     Both signatures must be identical. Flip one bit of y in sample 13 -> signature differs.

Source files
------------

// File: rtl/y_signature_misr.sv
// Compacts a wide result bus into a multiple-input signature register over a fixed window.
// The signature is then offered on a valid/ready handshake.
module y_signature_misr #(
  parameter int                   Y_WIDTH     = 446,
  parameter int                   SIG_WIDTH   = 32,
  parameter logic [SIG_WIDTH-1:0] POLY        = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] SEED        = 32'h0,
  parameter int                   NUM_SAMPLES = 20,
  localparam int                  CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [Y_WIDTH-1:0]   y,
  input  logic                 start,
  output logic                 busy,
  output logic                 sig_valid,
  input  logic                 sig_ready,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [CNT_W-1:0]     sample_count
);

  localparam int             NCH  = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HOLD} state_t;

  state_t                 state_q;
  logic                   busy_q;
  logic                   valid_q;
  logic [SIG_WIDTH-1:0]   sig_q;
  logic [SIG_WIDTH-1:0]   sig_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;

  // Zero-extend y to a whole number of chunks, then XOR the chunks together.
  function automatic logic [SIG_WIDTH-1:0] fold(input logic [Y_WIDTH-1:0] yv);
    logic [NCH*SIG_WIDTH-1:0] ext;
    logic [SIG_WIDTH-1:0]     acc;
    ext = '0;
    ext[Y_WIDTH-1:0] = yv;
    acc = '0;
    for (int k = 0; k < NCH; k++) begin
      acc = acc ^ ext[k*SIG_WIDTH +: SIG_WIDTH];
    end
    return acc;
  endfunction

  function automatic logic [SIG_WIDTH-1:0] misr_step(input logic [SIG_WIDTH-1:0] s,
                                                     input logic [SIG_WIDTH-1:0] f);
    return {s[SIG_WIDTH-2:0], 1'b0} ^ (s[SIG_WIDTH-1] ? POLY : '0) ^ f;
  endfunction

  always_comb begin
    sig_d = misr_step(sig_q, fold(y));
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sig_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_CAPTURE;
            busy_q  <= 1'b1;
            sig_q   <= SEED;
            cnt_q   <= '0;
          end
        end
        S_CAPTURE: begin
          sig_q <= sig_d;
          cnt_q <= cnt_d;
          // The final sample is absorbed on the same edge that enters HOLD.
          if (cnt_q == LAST) begin
            state_q <= S_HOLD;
            valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (sig_ready) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign sig_valid    = valid_q;
  assign signature    = sig_q;
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_y_signature_misr.sv
// Bench for y_signature_misr: a 20-sample instance driven through a scoreboard,
// plus three single-sample instances for seed and fold corner cases.
module tb_y_signature_misr;

  localparam int          YW   = 446;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 20-sample instance, SEED = 0
  logic [YW-1:0] y_a = '0;
  logic          start_a = 1'b0, ready_a = 1'b0;
  logic          busy_a, valid_a;
  logic [31:0]   sig_a;
  logic [4:0]    cnt_a;

  // single-sample instances sharing inputs
  logic [YW-1:0] y_b = '0;
  logic          start_b = 1'b0, ready_b = 1'b1;
  logic          busy_b0, valid_b0, busy_b8, valid_b8, busy_b1, valid_b1;
  logic [31:0]   sig_b0, sig_b8, sig_b1;
  logic [0:0]    cnt_b0, cnt_b8, cnt_b1;

  y_signature_misr #(.SEED(32'h0), .NUM_SAMPLES(20)) u_a (
    .clk(clk), .rst(rst), .y(y_a), .start(start_a), .busy(busy_a), .sig_valid(valid_a),
    .sig_ready(ready_a), .signature(sig_a), .sample_count(cnt_a));
  y_signature_misr #(.SEED(32'h0), .NUM_SAMPLES(1)) u_b0 (
    .clk(clk), .rst(rst), .y(y_b), .start(start_b), .busy(busy_b0), .sig_valid(valid_b0),
    .sig_ready(ready_b), .signature(sig_b0), .sample_count(cnt_b0));
  y_signature_misr #(.SEED(32'h80000000), .NUM_SAMPLES(1)) u_b8 (
    .clk(clk), .rst(rst), .y(y_b), .start(start_b), .busy(busy_b8), .sig_valid(valid_b8),
    .sig_ready(ready_b), .signature(sig_b8), .sample_count(cnt_b8));
  y_signature_misr #(.SEED(32'h1), .NUM_SAMPLES(1)) u_b1 (
    .clk(clk), .rst(rst), .y(y_b), .start(start_b), .busy(busy_b1), .sig_valid(valid_b1),
    .sig_ready(ready_b), .signature(sig_b1), .sample_count(cnt_b1));

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0]   sb_q[$];
  logic [YW-1:0] vecs[20];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference step: bit i of y lands on signature bit i mod 32.
  function automatic logic [31:0] m_step(input logic [31:0] s, input logic [YW-1:0] yv);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < YW; i++) f[i % 32] = f[i % 32] ^ yv[i];
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  // Start a window on u_a and feed vecs[]; pushes the model signature.
  task automatic launch(input bit flip);
    logic [31:0]   m;
    logic [YW-1:0] yv;
    m = 32'h0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 19) chk("early_valid", 64'(valid_a), 64'h0);
      yv = vecs[i];
      if (flip && i == 13) yv[100] = ~yv[100];
      y_a = yv;
      m = m_step(m, yv);
      @(negedge clk);
    end
    sb_q.push_back(m);
  endtask

  // Wait (bounded) for sig_valid, then pop and compare; leaves u_a in HOLD.
  task automatic collect(input string tag, output logic [31:0] got);
    int waited;
    logic [31:0] exp;
    waited = 0;
    while (!valid_a && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_latency"}, 64'(waited), 64'h0);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEADBEEF;
    chk({tag, "_sig"}, 64'(sig_a), 64'(exp));
    chk({tag, "_cnt"}, 64'(cnt_a), 64'd20);
    got = sig_a;
  endtask

  task automatic handshake(input string tag);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    chk({tag, "_idle_busy"}, 64'(busy_a), 64'h0);
    chk({tag, "_idle_valid"}, 64'(valid_a), 64'h0);
  endtask

  task automatic pulse_b(input logic [YW-1:0] yv);
    start_b = 1'b1;
    y_b = yv;
    @(negedge clk);
    start_b = 1'b0;
    @(negedge clk);
  endtask

  initial begin : main
    logic [31:0]   s1, s2, s3, held;
    logic [YW-1:0] yv;
    logic [447:0]  tmp;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy_a), 64'h0);
    chk("rst_valid", 64'(valid_a), 64'h0);
    chk("rst_sig", 64'(sig_a), 64'h0);
    chk("rst_cnt", 64'(cnt_a), 64'h0);

    // T1: all-zero stimulus keeps a zero seed at zero
    for (int i = 0; i < 20; i++) vecs[i] = '0;
    launch(1'b0);
    collect("t1", s1);
    handshake("t1");
    chk("t1_retained_cnt", 64'(cnt_a), 64'd20);

    // T2/T3 on single-sample instances
    pulse_b('0);
    chk("t2_seed8", 64'(sig_b8), 64'h04C11DB7);
    chk("t2_seed1", 64'(sig_b1), 64'h2);
    chk("t2_valid", 64'({valid_b0, valid_b8, valid_b1}), 64'h7);
    chk("t2_cnt", 64'({cnt_b0, cnt_b8, cnt_b1}), 64'h7);
    @(negedge clk);
    chk("t2_idle", 64'({busy_b0, busy_b8, busy_b1}), 64'h0);
    yv = '0; yv[0] = 1'b1;
    pulse_b(yv);
    chk("t3_bit0", 64'(sig_b0), 64'h1);
    @(negedge clk);
    yv = '0; yv[32] = 1'b1;
    pulse_b(yv);
    chk("t3_bit32", 64'(sig_b0), 64'h1);
    @(negedge clk);
    yv[0] = 1'b1;
    pulse_b(yv);
    chk("t3_bit32_0", 64'(sig_b0), 64'h0);
    @(negedge clk);
    yv = '0; yv[445] = 1'b1;
    pulse_b(yv);
    chk("t3_bit445", 64'(sig_b0), 64'h20000000);

    // T6: random vectors, replayed twice, then with one bit flipped
    for (int i = 0; i < 20; i++) begin
      for (int w = 0; w < 14; w++) tmp[w*32 +: 32] = $urandom;
      vecs[i] = tmp[YW-1:0];
    end
    launch(1'b0);
    collect("t6a", s1);
    handshake("t6a");
    launch(1'b0);
    collect("t6b", s2);
    chk("t6_replay", 64'(s2), 64'(s1));

    // T4: hold with ready low while y and start toggle
    held = sig_a;
    for (int i = 0; i < 5; i++) begin
      y_a = ~vecs[i];
      start_a = i[0];
      @(negedge clk);
      chk("t4_valid", 64'(valid_a), 64'h1);
      chk("t4_sig", 64'(sig_a), 64'(held));
      chk("t4_cnt", 64'(cnt_a), 64'd20);
    end
    start_a = 1'b1;
    handshake("t4");
    start_a = 1'b0;
    chk("t4_sig_kept", 64'(sig_a), 64'(held));
    @(negedge clk);
    chk("t4_start_ignored", 64'(busy_a), 64'h0);

    launch(1'b1);
    collect("t6c", s3);
    chk("t6_flip_differs", 64'(s3 != s1), 64'h1);
    handshake("t6c");

    // T5: reset after 7 samples, then rerun
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      y_a = vecs[i];
      @(negedge clk);
    end
    chk("t5_mid_cnt", 64'(cnt_a), 64'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 64'(busy_a), 64'h0);
    chk("t5_valid", 64'(valid_a), 64'h0);
    chk("t5_sig", 64'(sig_a), 64'h0);
    chk("t5_cnt", 64'(cnt_a), 64'h0);
    launch(1'b0);
    collect("t5", s2);
    chk("t5_same_as_full", 64'(s2), 64'(s1));
    handshake("t5");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
